lc3_operate_sequencer: RTL and testbench
========================================

Name: lc3_operate_sequencer

Overview:
Multicycle control FSM that fetches LC-3 instructions over a memory request/ready handshake, decodes them, and sequences the shared ALU datapath for ADD, AND and NOT. It also executes BR against the condition codes it maintains. It sits between instruction memory, the register file and the ALU. It drives the ALU control/immediate fields and register read/write addresses, and writes ALU results back.

Parameters:
RESET_PC  16'h3000  PC value loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
mem_req  output  1  instruction fetch request
mem_addr  output  16  fetch address (= pc while mem_req high)
mem_rdata  input  16  instruction word, valid when mem_ready high
mem_ready  input  1  fetch completion strobe
sr1  output  3  register file read address A (drives ALU Ra)
sr2  output  3  register file read address B (drives ALU Rb)
alu_ctrl  output  2  ALU operation: 0 pass A, 1 add, 2 and, 3 not
alu_ir  output  6  ALU immediate field = ir[5:0]
alu_out  input  16  ALU result, combinational from sr1/sr2/alu_ctrl/alu_ir
reg_we  output  1  register write enable, one-cycle pulse
dr  output  3  register write address
reg_wdata  output  16  write data (= alu_out)
pc  output  16  current program counter
nzp  output  3  condition codes {N,Z,P}
illegal  output  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Reset (rst high at a clk edge, any state): state=FETCH, pc=RESET_PC, ir=0, nzp=3'b010, mem_req=0, reg_we=0, illegal=0, alu_ctrl=0, sr1=sr2=dr=0. Reset mid-fetch abandons the fetch; a mem_ready arriving during or after reset is ignored.
- States: FETCH -> DECODE -> EXEC -> FETCH.
- FETCH: mem_req=1 and mem_addr=pc, both held stable until mem_ready is sampled high. On that edge: ir<=mem_rdata, pc<=pc+1 (wraps 16'hFFFF->0), go to DECODE. mem_req rises in the first cycle after reset deasserts. mem_ready while mem_req=0 is ignored.
- DECODE: sr1=ir[8:6], sr2=ir[2:0], dr=ir[11:9], alu_ir=ir[5:0]. alu_ctrl set from opcode ir[15:12]: 0001->1, 0101->2, 1001->3, other->0. Registered so the values are stable throughout EXEC.
- EXEC, opcode 0001/0101/1001: reg_we=1 for exactly this cycle, reg_wdata=alu_out. nzp<= {alu_out[15], alu_out==0, !alu_out[15] && alu_out!=0}; exactly one bit is set.
- EXEC, opcode 0000 (BR): if (ir[11:9] & nzp)!=0 then pc<=pc+sext(ir[8:0]) (16-bit wrap); else pc unchanged. nzp is not modified and reg_we stays 0. ir[11:9]=000 never branches.
- EXEC, any other opcode: illegal=1 for one cycle. No write, pc/nzp unchanged, execution continues.
- Throughput: an instruction takes 3 cycles when mem_ready returns in the first FETCH cycle, plus one cycle per wait cycle.
- reg_we and illegal are never high outside EXEC. mem_req is never high outside FETCH.

Test Plan:
- Reset with RESET_PC=16'h3000 -> pc=3000, nzp=010, mem_req=0; the next cycle mem_req=1 with mem_addr=3000; reg_we and illegal stay 0.
- Fetch 16'h1261 (ADD R1,R1,#1) with R1=5 and mem_ready delayed 3 cycles -> mem_addr held at 3000 for 4 cycles; then reg_we pulses once with dr=1, alu_ctrl=1, reg_wdata=6; nzp=001; pc=3001.
- Fetch 16'h5020 (AND R0,R0,#0) -> reg_wdata=0, nzp=010. Then 16'h987F (NOT R4,R1) with R1=0 -> reg_wdata=FFFF, nzp=100.
- With nzp=010 at pc=3004: fetch 16'h05FD (BRz #-3) -> pc=3002. Fetch 16'h0A05 (BRnp) -> pc incremented only; nzp unchanged.
- Fetch 16'hD000 -> illegal pulses once, no reg_we, pc advances by 1.
- Assert rst while FETCH is waiting, with mem_ready arriving in the reset cycle -> ir is not loaded; pc=RESET_PC; fetch restarts.

Source files
------------

// File: rtl/lc3_operate_sequencer_if.sv
// Sequencer-to-datapath bundle: instruction fetch handshake, register file / ALU control, and status.
// The master modport is the sequencer side; the slave modport is memory, register file and ALU.
interface lc3_operate_sequencer_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [1:0]  alu_ctrl;
  logic [5:0]  alu_ir;
  logic [15:0] alu_out;
  logic        reg_we;
  logic [2:0]  dr;
  logic [15:0] reg_wdata;
  logic [15:0] pc;
  logic [2:0]  nzp;
  logic        illegal;

  modport master (
    output mem_req, mem_addr, sr1, sr2, alu_ctrl, alu_ir, reg_we, dr, reg_wdata, pc, nzp, illegal,
    input  mem_rdata, mem_ready, alu_out
  );

  modport slave (
    input  mem_req, mem_addr, sr1, sr2, alu_ctrl, alu_ir, reg_we, dr, reg_wdata, pc, nzp, illegal,
    output mem_rdata, mem_ready, alu_out
  );
endinterface

// File: rtl/lc3_operate_sequencer.sv
// LC-3 FETCH/DECODE/EXEC sequencer for ADD/AND/NOT/BR: 3 cycles per instruction plus fetch wait cycles.
// Backpressure: mem_req and mem_addr hold until mem_ready; mem_ready is ignored whenever mem_req is low.
module lc3_operate_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic                          clk,
  input  logic                          rst,
  lc3_operate_sequencer_if.master       bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc_q;
  logic [15:0] ir;
  logic [2:0]  nzp_q;
  logic        mem_req_q;
  logic        reg_we_q;
  logic        illegal_q;
  logic [1:0]  alu_ctrl_q;
  logic [5:0]  alu_ir_q;
  logic [2:0]  sr1_q;
  logic [2:0]  sr2_q;
  logic [2:0]  dr_q;

  logic [3:0]  opcode;
  logic        is_alu;
  logic        is_br;
  logic        br_taken;
  logic [15:0] br_off;

  assign opcode   = ir[15:12];
  assign is_alu   = (opcode == 4'b0001) || (opcode == 4'b0101) || (opcode == 4'b1001);
  assign is_br    = (opcode == 4'b0000);
  assign br_taken = (ir[11:9] & nzp_q) != 3'b000;
  assign br_off   = {{7{ir[8]}}, ir[8:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc_q       <= RESET_PC;
      ir         <= 16'h0000;
      nzp_q      <= 3'b010;
      mem_req_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      illegal_q  <= 1'b0;
      alu_ctrl_q <= 2'd0;
      alu_ir_q   <= 6'd0;
      sr1_q      <= 3'd0;
      sr2_q      <= 3'd0;
      dr_q       <= 3'd0;
    end else begin
      case (state)
        FETCH: begin
          // The first FETCH cycle after reset only raises the request.
          if (!mem_req_q) begin
            mem_req_q <= 1'b1;
          end else if (bus.mem_ready) begin
            ir        <= bus.mem_rdata;
            pc_q      <= pc_q + 16'd1;
            mem_req_q <= 1'b0;
            state     <= DECODE;
          end
        end
        DECODE: begin
          sr1_q    <= ir[8:6];
          sr2_q    <= ir[2:0];
          dr_q     <= ir[11:9];
          alu_ir_q <= ir[5:0];
          case (opcode)
            4'b0001: alu_ctrl_q <= 2'd1;
            4'b0101: alu_ctrl_q <= 2'd2;
            4'b1001: alu_ctrl_q <= 2'd3;
            default: alu_ctrl_q <= 2'd0;
          endcase
          reg_we_q  <= is_alu;
          illegal_q <= !is_alu && !is_br;
          state     <= EXEC;
        end
        EXEC: begin
          if (is_alu) begin
            nzp_q <= {bus.alu_out[15],
                      bus.alu_out == 16'h0000,
                      !bus.alu_out[15] && (bus.alu_out != 16'h0000)};
          end else if (is_br && br_taken) begin
            pc_q <= pc_q + br_off;
          end
          reg_we_q  <= 1'b0;
          illegal_q <= 1'b0;
          mem_req_q <= 1'b1;
          state     <= FETCH;
        end
        default: begin
          mem_req_q <= 1'b0;
          reg_we_q  <= 1'b0;
          illegal_q <= 1'b0;
          state     <= FETCH;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = pc_q;
  assign bus.sr1       = sr1_q;
  assign bus.sr2       = sr2_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.alu_ir    = alu_ir_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.dr        = dr_q;
  assign bus.reg_wdata = bus.alu_out;
  assign bus.pc        = pc_q;
  assign bus.nzp       = nzp_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_lc3_operate_sequencer.sv
// Randomized bench for lc3_operate_sequencer: instruction-level reference model feeds a scoreboard,
// a monitor pops one expectation at every new fetch request.
module tb_lc3_operate_sequencer;

  localparam logic [15:0] RST_PC = 16'h3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lc3_operate_sequencer_if bus();

  lc3_operate_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] pc;
    logic [2:0]  nzp;
    int          we;
    logic [2:0]  dr;
    logic [15:0] wd;
    int          ill;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mregs[8];
  logic [15:0] mpc;
  logic [2:0]  mnzp;

  // Environment: register file written by the DUT, ALU driven by the DUT's control fields.
  logic [15:0] rf[8];
  logic [15:0] init_rf[8];
  logic        load_rf;
  logic [15:0] alu_a, alu_b, alu_val;

  always @(posedge clk) begin
    if (load_rf) begin
      for (int i = 0; i < 8; i++) rf[i] <= init_rf[i];
    end else if (bus.reg_we) begin
      rf[bus.dr] <= bus.reg_wdata;
    end
  end

  always_comb begin
    alu_a   = rf[bus.sr1];
    alu_b   = bus.alu_ir[5] ? {{11{bus.alu_ir[4]}}, bus.alu_ir[4:0]} : rf[bus.sr2];
    alu_val = alu_a;
    case (bus.alu_ctrl)
      2'd1:    alu_val = alu_a + alu_b;
      2'd2:    alu_val = alu_a & alu_b;
      2'd3:    alu_val = ~alu_a;
      default: alu_val = alu_a;
    endcase
  end
  assign bus.alu_out = alu_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  function automatic exp_t reset_entry();
    exp_t e;
    e.pc = RST_PC; e.nzp = 3'b010; e.we = 0; e.dr = 3'd0; e.wd = 16'h0; e.ill = 0; e.cyc = 0;
    return e;
  endfunction

  // Reference model: one whole instruction at a time, plain integer arithmetic.
  task automatic model_exec(input logic [15:0] ins, input int dly, output exp_t e);
    int          imm;
    int          off;
    logic [15:0] src1, src2, res;
    e.we = 0; e.dr = 3'd0; e.wd = 16'h0; e.ill = 0; e.cyc = dly + 3;
    mpc  = mpc + 16'd1;
    src1 = mregs[ins[8:6]];
    imm  = ins[4] ? int'(ins[4:0]) - 32 : int'(ins[4:0]);
    src2 = ins[5] ? 16'(imm) : mregs[ins[2:0]];
    res  = 16'h0;
    case (ins[15:12])
      4'h1, 4'h5, 4'h9: begin
        if (ins[15:12] == 4'h1)      res = 16'(int'(src1) + int'(src2));
        else if (ins[15:12] == 4'h5) res = src1 & src2;
        else                         res = 16'hFFFF - src1;
        mregs[ins[11:9]] = res;
        if (res >= 16'h8000)   mnzp = 3'b100;
        else if (res == 16'h0) mnzp = 3'b010;
        else                   mnzp = 3'b001;
        e.we = 1; e.dr = ins[11:9]; e.wd = res;
      end
      4'h0: begin
        off = ins[8] ? int'(ins[8:0]) - 512 : int'(ins[8:0]);
        if ((ins[11] && mnzp[2]) || (ins[10] && mnzp[1]) || (ins[9] && mnzp[0]))
          mpc = 16'(int'(mpc) + off);
      end
      default: e.ill = 1;
    endcase
    e.pc  = mpc;
    e.nzp = mnzp;
  endtask

  function automatic logic [15:0] gen_instr();
    int          k;
    logic [15:0] w;
    logic [3:0]  bad_ops[12];
    bad_ops = '{4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    k = $urandom_range(0, 9);
    w = 16'($urandom);
    case (k)
      0, 1, 2: w[15:12] = 4'h1;
      3, 4:    w[15:12] = 4'h5;
      5:       w[15:12] = 4'h9;
      6, 7:    w[15:12] = 4'h0;
      8:       w[15:12] = bad_ops[$urandom_range(0, 11)];
      default: begin w[15:12] = 4'h0; w[11:9] = 3'b111; end
    endcase
    return w;
  endfunction

  // Monitor: sampled 2 time units after each rising edge.
  logic        prev_req = 1'b0;
  logic        prev_we  = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  int          we_cnt = 0, ill_cnt = 0, cyc_cnt = 0;
  logic [2:0]  seen_dr = 3'd0;
  logic [15:0] seen_wd = 16'h0;
  exp_t        mon_e;

  always @(posedge clk) begin
    #2;
    if (rst) begin
      prev_req = 1'b0; prev_we = 1'b0; we_cnt = 0; ill_cnt = 0; cyc_cnt = 0;
    end else begin
      cyc_cnt++;
      if (bus.reg_we) begin we_cnt++; seen_dr = bus.dr; seen_wd = bus.reg_wdata; end
      if (bus.illegal) ill_cnt++;
      chk("strobe_during_fetch", {31'd0, bus.mem_req & (bus.reg_we | bus.illegal)}, 32'd0);
      chk("reg_we_single_pulse", {31'd0, prev_we & bus.reg_we}, 32'd0);
      if (bus.mem_req && prev_req) chk("mem_addr_hold", bus.mem_addr, prev_addr);
      if (bus.mem_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          tests++; errors++;
          $display("FAIL sb_underflow: fetch at %h with no expected entry", bus.mem_addr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("fetch_addr", bus.mem_addr, mon_e.pc);
          chk("pc_port", bus.pc, mon_e.pc);
          chk("nzp", bus.nzp, mon_e.nzp);
          chk("reg_we_count", we_cnt, mon_e.we);
          if (mon_e.we == 1) begin
            chk("write_dr", seen_dr, mon_e.dr);
            chk("write_data", seen_wd, mon_e.wd);
          end
          chk("illegal_count", ill_cnt, mon_e.ill);
          if (mon_e.cyc != 0) chk("instr_cycles", cyc_cnt, mon_e.cyc);
        end
        we_cnt = 0; ill_cnt = 0; cyc_cnt = 0;
      end
      prev_req  = bus.mem_req;
      prev_addr = bus.mem_addr;
      prev_we   = bus.reg_we;
    end
  end

  task automatic wait_req(output int ok);
    int guard = 0;
    while (!bus.mem_req && guard < 20) begin @(negedge clk); guard++; end
    ok = bus.mem_req ? 1 : 0;
    if (ok == 0) begin
      tests++; errors++;
      $display("FAIL fetch_timeout: mem_req low for %0d cycles, required high", guard);
    end
  endtask

  task automatic fetch_one(input logic [15:0] ins, input int dly);
    exp_t e;
    int   ok;
    wait_req(ok);
    if (ok == 0) return;
    repeat (dly) @(negedge clk);
    model_exec(ins, dly, e);
    exp_q.push_back(e);
    bus.mem_rdata = ins;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'($urandom);
    // Stray ready while no request is outstanding must be ignored.
    if ($urandom_range(0, 2) == 0) begin
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
    end
  endtask

  initial begin
    int ok;
    int g;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'h0;
    load_rf = 1'b1;
    for (int i = 0; i < 8; i++) init_rf[i] = 16'($urandom);
    init_rf[1] = 16'd5;
    mregs = init_rf;
    mpc   = RST_PC;
    mnzp  = 3'b010;
    exp_q.push_back(reset_entry());
    rst = 1'b1;
    repeat (2) @(negedge clk);

    chk("reset_pc", bus.pc, RST_PC);
    chk("reset_nzp", bus.nzp, 3'b010);
    chk("reset_mem_req", bus.mem_req, 1'b0);
    chk("reset_reg_we", bus.reg_we, 1'b0);
    chk("reset_illegal", bus.illegal, 1'b0);
    chk("reset_alu_ctrl", bus.alu_ctrl, 2'd0);
    chk("reset_dr", bus.dr, 3'd0);

    load_rf = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", bus.mem_req, 1'b1);
    chk("first_addr", bus.mem_addr, RST_PC);

    fetch_one(16'h1261, 3);
    fetch_one(16'h5260, 0);
    fetch_one(16'h987F, 1);
    fetch_one(16'h5020, 0);
    fetch_one(16'h05FD, 2);
    fetch_one(16'h0A05, 0);
    fetch_one(16'hD000, 0);
    wait_req(ok);
    chk("directed_pc", bus.mem_addr, 16'h3004);
    chk("directed_nzp", bus.nzp, 3'b010);
    chk("directed_r4", rf[4], 16'hFFFF);
    chk("directed_r1", rf[1], 16'h0000);

    for (int n = 0; n < 200; n++) fetch_one(gen_instr(), $urandom_range(0, 3));

    // Reset while a fetch is waiting, with mem_ready arriving in the reset cycle and the one after.
    wait_req(ok);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'h1261;
    exp_q.delete();
    mpc  = RST_PC;
    mnzp = 3'b010;
    exp_q.push_back(reset_entry());
    @(negedge clk);
    chk("midreset_pc", bus.pc, RST_PC);
    chk("midreset_nzp", bus.nzp, 3'b010);
    chk("midreset_mem_req", bus.mem_req, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("restart_req", bus.mem_req, 1'b1);
    chk("restart_addr", bus.mem_addr, RST_PC);

    for (int n = 0; n < 40; n++) fetch_one(gen_instr(), $urandom_range(0, 3));

    g = 0;
    while (exp_q.size() != 0 && g < 20) begin @(negedge clk); g++; end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
